// File: rtl/huffman_code_pkg.sv
// Shared constants, record and state types for the huffman_code coder.
package huffman_pkg;

    localparam int NUM_SYM = 10;
    localparam int SYM_W   = 4;
    localparam int CNT_W   = 15;
    localparam int REC_W   = 19;
    localparam int LEN_W   = 4;
    localparam int CODE_W  = 9;
    localparam int MAX_LEN = 9;

    typedef struct packed {
        logic [SYM_W-1:0] sym;
        logic [CNT_W-1:0] cnt;
    } rec_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MERGE = 3'd2,
        ST_CANON = 3'd3,
        ST_DONE  = 3'd4
    } coder_state_t;

    typedef enum logic [1:0] {
        FC_IDLE  = 2'd0,
        FC_COUNT = 2'd1,
        FC_REQ   = 2'd2
    } fc_state_t;

endpackage

// File: rtl/huffman_code_freq_count.sv
// Framed symbol-frequency counter with saturating 15-bit counts and a
// req/ack handoff of the ten {symbol, count} records to the coder.
module freq_count
    import huffman_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_ok,
    input  logic                     start_done,
    input  logic [SYM_W-1:0]         data_in,
    input  logic                     ack_coding,
    output logic                     req_coding,
    output rec_t [NUM_SYM-1:0]       recs
);

    fc_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q [NUM_SYM];
    logic [CNT_W-1:0]       cnt_d [NUM_SYM];

    // Window state register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FC_IDLE;
            for (int i = 0; i < NUM_SYM; i++) cnt_q[i] <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            for (int i = 0; i < NUM_SYM; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Window next state; values 10..15 match no counter and are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            FC_IDLE: begin
                if (start_ok) begin
                    state_d = FC_COUNT;
                    for (int i = 0; i < NUM_SYM; i++) cnt_d[i] = {CNT_W{1'b0}};
                end else begin
                    state_d = FC_IDLE;
                end
            end
            FC_COUNT: begin
                if (start_done) begin
                    state_d = FC_REQ;
                end else begin
                    for (int i = 0; i < NUM_SYM; i++) begin
                        if (data_in == SYM_W'(i) && cnt_q[i] != {CNT_W{1'b1}}) begin
                            cnt_d[i] = cnt_q[i] + 15'd1;
                        end else begin
                            cnt_d[i] = cnt_q[i];
                        end
                    end
                end
            end
            FC_REQ: begin
                if (ack_coding) state_d = FC_IDLE;
                else            state_d = FC_REQ;
            end
            default: state_d = FC_IDLE;
        endcase
    end

    // Record view of the counters.
    always_comb begin
        for (int i = 0; i < NUM_SYM; i++) begin
            recs[i].sym = SYM_W'(i);
            recs[i].cnt = cnt_q[i];
        end
    end

    assign req_coding = (state_q == FC_REQ);

endmodule

// File: rtl/huffman_code.sv
// Streaming Huffman coder: counts a symbol window, merges minimum pairs to get
// code lengths, then assigns canonical codewords. HUFFMAN_FREQ_OUT_EN adds freq_out.
module huffman_code
    import huffman_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        start_done,
    input  logic [SYM_W-1:0]            data_in,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_SYM*LEN_W-1:0]    len_out,
    output logic [NUM_SYM*CODE_W-1:0]   code_out
`ifdef HUFFMAN_FREQ_OUT_EN
    ,
    output logic [NUM_SYM*REC_W-1:0]    freq_out
`endif
);

    coder_state_t               state_q, state_d;
    logic                       busy_q, busy_d, done_q, done_d;
    logic [NUM_SYM*LEN_W-1:0]   len_out_q, len_out_d;
    logic [NUM_SYM*CODE_W-1:0]  code_out_q, code_out_d;
    logic [NUM_SYM-1:0]         active_q, active_d;
    logic [REC_W-1:0]           w_q [NUM_SYM];
    logic [REC_W-1:0]           w_d [NUM_SYM];
    logic [SYM_W-1:0]           grp_q [NUM_SYM];
    logic [SYM_W-1:0]           grp_d [NUM_SYM];
    logic [LEN_W-1:0]           len_q [NUM_SYM];
    logic [LEN_W-1:0]           len_d [NUM_SYM];
    logic [CODE_W-1:0]          code_q [NUM_SYM];
    logic [CODE_W-1:0]          code_d [NUM_SYM];
    logic [SYM_W-1:0]           nact_q, nact_d, lvl_q, lvl_d;
    logic [CODE_W:0]            c_q, c_d, run_s;
    logic [SYM_W-1:0]           n_nz_s, a_idx_s, b_idx_s, lo_s, hi_s;
    logic [REC_W-1:0]           wa_s, wb_s;
    logic                       a_ok_s, b_ok_s, req_coding_s, ack_coding_s, start_ok_s;
    rec_t [NUM_SYM-1:0]         recs_s;

    assign start_ok_s   = start && !busy_q;
    assign ack_coding_s = (state_q == ST_LOAD);

    freq_count u_freq_count (
        .clk        (clk),
        .rst        (rst),
        .start_ok   (start_ok_s),
        .start_done (start_done),
        .data_in    (data_in),
        .ack_coding (ack_coding_s),
        .req_coding (req_coding_s),
        .recs       (recs_s)
    );

`ifdef HUFFMAN_FREQ_OUT_EN
    assign freq_out = recs_s;
`endif

    // Coder state and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            len_out_q  <= {(NUM_SYM*LEN_W){1'b0}};
            code_out_q <= {(NUM_SYM*CODE_W){1'b0}};
            active_q   <= {NUM_SYM{1'b0}};
            nact_q     <= 4'd0;
            lvl_q      <= 4'd0;
            c_q        <= 10'd0;
            for (int i = 0; i < NUM_SYM; i++) begin
                w_q[i]    <= {REC_W{1'b0}};
                grp_q[i]  <= 4'd0;
                len_q[i]  <= 4'd0;
                code_q[i] <= 9'd0;
            end
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            len_out_q  <= len_out_d;
            code_out_q <= code_out_d;
            active_q   <= active_d;
            nact_q     <= nact_d;
            lvl_q      <= lvl_d;
            c_q        <= c_d;
            for (int i = 0; i < NUM_SYM; i++) begin
                w_q[i]    <= w_d[i];
                grp_q[i]  <= grp_d[i];
                len_q[i]  <= len_d[i];
                code_q[i] <= code_d[i];
            end
        end
    end

    // Pair selection: strict less-than keeps the lowest index on ties.
    always_comb begin
        a_idx_s = 4'd0;
        wa_s    = {REC_W{1'b0}};
        a_ok_s  = 1'b0;
        b_idx_s = 4'd0;
        wb_s    = {REC_W{1'b0}};
        b_ok_s  = 1'b0;
        for (int i = 0; i < NUM_SYM; i++) begin
            if (active_q[i] && (!a_ok_s || w_q[i] < wa_s)) begin
                a_idx_s = SYM_W'(i);
                wa_s    = w_q[i];
                a_ok_s  = 1'b1;
            end else begin
                a_ok_s  = a_ok_s;
            end
        end
        for (int i = 0; i < NUM_SYM; i++) begin
            if (active_q[i] && SYM_W'(i) != a_idx_s && (!b_ok_s || w_q[i] < wb_s)) begin
                b_idx_s = SYM_W'(i);
                wb_s    = w_q[i];
                b_ok_s  = 1'b1;
            end else begin
                b_ok_s  = b_ok_s;
            end
        end
        lo_s = (a_idx_s < b_idx_s) ? a_idx_s : b_idx_s;
        hi_s = (a_idx_s < b_idx_s) ? b_idx_s : a_idx_s;
    end

    // Coder next state: load, merge, canonical assignment, publish.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        len_out_d  = len_out_q;
        code_out_d = code_out_q;
        active_d   = active_q;
        nact_d     = nact_q;
        lvl_d      = lvl_q;
        c_d        = c_q;
        w_d        = w_q;
        grp_d      = grp_q;
        len_d      = len_q;
        code_d     = code_q;
        run_s      = c_q;
        n_nz_s     = 4'd0;
        if (start_ok_s) busy_d = 1'b1;
        else            busy_d = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (req_coding_s) state_d = ST_LOAD;
                else              state_d = ST_IDLE;
            end
            ST_LOAD: begin
                for (int i = 0; i < NUM_SYM; i++) begin
                    if (recs_s[i].cnt != 15'd0) n_nz_s = n_nz_s + 4'd1;
                    else                        n_nz_s = n_nz_s;
                end
                for (int i = 0; i < NUM_SYM; i++) begin
                    w_d[i]      = {4'd0, recs_s[i].cnt};
                    active_d[i] = (recs_s[i].cnt != 15'd0);
                    grp_d[i]    = SYM_W'(i);
                    len_d[i]    = (n_nz_s == 4'd1 && recs_s[i].cnt != 15'd0) ? 4'd1 : 4'd0;
                    code_d[i]   = 9'd0;
                end
                nact_d  = n_nz_s;
                lvl_d   = 4'd1;
                c_d     = 10'd0;
                state_d = (n_nz_s >= 4'd2) ? ST_MERGE : ST_CANON;
            end
            ST_MERGE: begin
                for (int i = 0; i < NUM_SYM; i++) begin
                    if (SYM_W'(i) == lo_s) w_d[i] = wa_s + wb_s;
                    else                   w_d[i] = w_q[i];
                    if (SYM_W'(i) == hi_s) active_d[i] = 1'b0;
                    else                   active_d[i] = active_q[i];
                    if (grp_q[i] == a_idx_s || grp_q[i] == b_idx_s) len_d[i] = len_q[i] + 4'd1;
                    else                                            len_d[i] = len_q[i];
                    if (grp_q[i] == hi_s) grp_d[i] = lo_s;
                    else                  grp_d[i] = grp_q[i];
                end
                nact_d  = nact_q - 4'd1;
                state_d = (nact_q == 4'd2) ? ST_CANON : ST_MERGE;
            end
            ST_CANON: begin
                for (int i = 0; i < NUM_SYM; i++) begin
                    if (len_q[i] == lvl_q) begin
                        code_d[i] = run_s[CODE_W-1:0];
                        run_s     = run_s + 10'd1;
                    end else begin
                        code_d[i] = code_q[i];
                    end
                end
                c_d   = run_s << 1;
                lvl_d = lvl_q + 4'd1;
                if (lvl_q == 4'(MAX_LEN)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    for (int i = 0; i < NUM_SYM; i++) begin
                        len_out_d[i*LEN_W +: LEN_W]    = len_q[i];
                        code_out_d[i*CODE_W +: CODE_W] = code_d[i];
                    end
                end else begin
                    state_d = ST_CANON;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign len_out  = len_out_q;
    assign code_out = code_out_q;

endmodule

// File: tb/tb_huffman_code.sv
// Scoreboard bench for huffman_code: stimulus queues expected results, a forked
// monitor compares them whenever done pulses.
module tb_huffman_code;

    logic         clk = 1'b0;
    logic         rst, start, start_done;
    logic [3:0]   data_in;
    logic         busy, done;
    logic [39:0]  len_out;
    logic [89:0]  code_out;
`ifdef HUFFMAN_FREQ_OUT_EN
    logic [189:0] freq_out;
`endif

    typedef struct {
        logic [39:0] len;
        logic [89:0] code;
        int          due;
        bit          kraft;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] stim_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         mid_start = -1;

    huffman_code dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_done (start_done),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .len_out    (len_out),
        .code_out   (code_out)
`ifdef HUFFMAN_FREQ_OUT_EN
        ,
        .freq_out   (freq_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [39:0] pack_len(input int l[10]);
        logic [39:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r[4*i +: 4] = l[i][3:0];
        return r;
    endfunction

    function automatic logic [89:0] pack_code(input int c[10]);
        logic [89:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r[9*i +: 9] = c[i][8:0];
        return r;
    endfunction

    // Start cycle and start_done cycle carry symbol 9, which must not be counted.
    task automatic send_frame(output int t);
        @(negedge clk);
        start = 1'b1; start_done = 1'b0; data_in = 4'd9;
        for (int i = 0; i < stim_q.size(); i++) begin
            @(negedge clk);
            start   = (i == mid_start);
            data_in = stim_q[i];
        end
        @(negedge clk);
        start = 1'b0; start_done = 1'b1; data_in = 4'd9;
        t = cyc;
        chk("busy_high", {127'd0, busy}, 128'd1);
        @(negedge clk);
        start_done = 1'b0; data_in = 4'd0;
    endtask

    task automatic drain(input int limit);
        for (int k = 0; k < limit && sb.size() != 0; k++) @(negedge clk);
        chk("done_timeout_pending", 128'(sb.size()), 128'd0);
        sb.delete();
    endtask

    task automatic push_exp(input int l[10], input int c[10], input int due, input bit kraft);
        exp_t e;
        e.len = pack_len(l); e.code = pack_code(c); e.due = due; e.kraft = kraft;
        sb.push_back(e);
    endtask

    initial begin
        int t;
        int cnts[10];
        int lz[10];
        int cz[10];
        rst = 1'b1; start = 1'b0; start_done = 1'b0; data_in = 4'd0;
        lz = '{0,0,0,0,0,0,0,0,0,0};
        cz = '{0,0,0,0,0,0,0,0,0,0};

        fork
            forever begin
                @(negedge clk);
                if (!rst && done) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("done_cycle", 128'(cyc), 128'(e.due));
                        chk("busy_low_at_done", {127'd0, busy}, 128'd0);
                        if (e.kraft) begin
                            int ks, n3, n4;
                            logic [3:0] l;
                            ks = 0; n3 = 0; n4 = 0;
                            for (int i = 0; i < 10; i++) begin
                                l = len_out[4*i +: 4];
                                if (l != 4'd0) ks += 512 >> l;
                                if (l == 4'd3) n3++;
                                if (l == 4'd4) n4++;
                            end
                            chk("kraft_sum", 128'(ks), 128'd512);
                            chk("len3_count", 128'(n3), 128'd6);
                            chk("len4_count", 128'(n4), 128'd4);
                        end else begin
                            chk("len_out", 128'(len_out), 128'(e.len));
                            chk("code_out", 128'(code_out), 128'(e.code));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_done", {127'd0, done}, 128'd0);
        chk("reset_len", 128'(len_out), 128'd0);
        chk("reset_code", 128'(code_out), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Main frame, with a start inside the window and another during coding.
        cnts = '{5,1,3,2,9,7,4,8,6,0};
        stim_q.delete();
        for (int s = 0; s < 10; s++)
            for (int k = 0; k < cnts[s]; k++) stim_q.push_back(4'(s));
        mid_start = 10;
        send_frame(t);
        mid_start = -1;
        push_exp('{3,5,4,5,2,3,3,3,3,0}, '{2,30,14,31,0,3,4,5,6,0}, t + 20, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(60);
        repeat (5) @(negedge clk);
        chk("hold_len", 128'(len_out), 128'(pack_len('{3,5,4,5,2,3,3,3,3,0})));

        // Single symbol 7.
        stim_q.delete();
        repeat (4) stim_q.push_back(4'd7);
        send_frame(t);
        push_exp('{0,0,0,0,0,0,0,1,0,0}, cz, t + 12, 1'b0);
        drain(40);

        // Empty window.
        stim_q.delete();
        send_frame(t);
        push_exp(lz, cz, t + 12, 1'b0);
        drain(40);

        // Out-of-range symbols around a single symbol 3.
        stim_q.delete();
        stim_q = '{4'd12, 4'd3, 4'd13, 4'd14, 4'd15, 4'd10, 4'd11};
        send_frame(t);
        push_exp('{0,0,0,1,0,0,0,0,0,0}, cz, t + 12, 1'b0);
        drain(40);

        // Equal counts of 2: complete code with six length-3 and four length-4 words.
        stim_q.delete();
        for (int s = 0; s < 10; s++) begin
            stim_q.push_back(4'(s));
            stim_q.push_back(4'(s));
        end
        send_frame(t);
        push_exp(lz, cz, t + 21, 1'b1);
        drain(60);

        // Reset during MERGE: no done, outputs cleared.
        stim_q.delete();
        for (int s = 0; s < 10; s++)
            for (int k = 0; k < cnts[s]; k++) stim_q.push_back(4'(s));
        send_frame(t);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_done", {127'd0, done}, 128'd0);
        chk("abort_len", 128'(len_out), 128'd0);
        chk("abort_code", 128'(code_out), 128'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
